// File: rtl/axis_prot_verifier_v2.sv
// axis_prot_verifier_v2: AXI-Stream tx length/gap/id corrector with rx passthrough, timeout and sticky error status
module axis_prot_verifier_v2 #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int MAX_PACKET_BYTES = 1522,
  parameter int DISALLOW_INVALID_MID_PACKET_EGR = 1,
  parameter int OVERSIZE_DROP_REMAINDER = 1,
  parameter int INCLUDE_TIMEOUT_ERROR_INGR = 1,
  parameter int ERR_COUNT_WIDTH = 16,
  localparam int BYTES = AXIS_BUS_WIDTH / 8,
  localparam int IW = AXIS_ID_WIDTH > 0 ? AXIS_ID_WIDTH : 1,
  localparam int DW = AXIS_DEST_WIDTH > 0 ? AXIS_DEST_WIDTH : 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]  axis_tx_in_tdata,
  input  logic [IW-1:0]              axis_tx_in_tid,
  input  logic [DW-1:0]              axis_tx_in_tdest,
  input  logic [BYTES-1:0]           axis_tx_in_tkeep,
  input  logic                       axis_tx_in_tlast,
  input  logic                       axis_tx_in_tvalid,
  output logic                       axis_tx_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]  axis_tx_out_tdata,
  output logic [IW-1:0]              axis_tx_out_tid,
  output logic [DW-1:0]              axis_tx_out_tdest,
  output logic [BYTES-1:0]           axis_tx_out_tkeep,
  output logic                       axis_tx_out_tlast,
  output logic                       axis_tx_out_tvalid,
  input  logic                       axis_tx_out_tready,
  input  logic [AXIS_BUS_WIDTH-1:0]  axis_rx_in_tdata,
  input  logic [DW-1:0]              axis_rx_in_tdest,
  input  logic [BYTES-1:0]           axis_rx_in_tkeep,
  input  logic                       axis_rx_in_tlast,
  input  logic                       axis_rx_in_tvalid,
  output logic                       axis_rx_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]  axis_rx_out_tdata,
  output logic [DW-1:0]              axis_rx_out_tdest,
  output logic [BYTES-1:0]           axis_rx_out_tkeep,
  output logic                       axis_rx_out_tlast,
  output logic                       axis_rx_out_tvalid,
  input  logic                       axis_rx_out_tready,
  input  logic [15:0]                rx_timeout_cycles,
  output logic [3:0]                 err_status,
  input  logic [3:0]                 err_clear,
  output logic                       err_irq,
  output logic [ERR_COUNT_WIDTH-1:0] oversize_count
);
  localparam int CW = $clog2(MAX_PACKET_BYTES + BYTES);
  typedef enum logic [1:0] {IDLE, MID, DROP} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n, nb, sum;
  logic slot, fill, real_beat, beat, in_last, forced, e_last, id_ev, gap_ev, to_ev, stall;
  logic gap_seen, id_seen;
  logic [IW-1:0] tid_in, lock_tid;
  logic [DW-1:0] tdest_in, lock_tdest;
  logic [15:0] timer, timer_n, inc;
  assign tid_in = AXIS_ID_WIDTH > 0 ? axis_tx_in_tid : '0;
  assign tdest_in = AXIS_DEST_WIDTH > 0 ? axis_tx_in_tdest : '0;
  assign axis_tx_in_tready = state == DROP || slot;
  assign axis_rx_in_tready = axis_rx_out_tready;
  assign axis_rx_out_tdata = axis_rx_in_tdata;
  assign axis_rx_out_tdest = axis_rx_in_tdest;
  assign axis_rx_out_tkeep = axis_rx_in_tkeep;
  assign axis_rx_out_tlast = axis_rx_in_tlast;
  assign axis_rx_out_tvalid = axis_rx_in_tvalid;
  assign err_irq = |err_status;
  always_comb begin
    slot = axis_tx_out_tready || !axis_tx_out_tvalid;
    fill = state == MID && DISALLOW_INVALID_MID_PACKET_EGR != 0 && !axis_tx_in_tvalid && slot;
    real_beat = axis_tx_in_tvalid && slot && state != DROP;
    beat = real_beat || fill;
    nb = fill ? '0 : CW'($countones(axis_tx_in_tkeep));
    sum = count + nb;
    in_last = axis_tx_in_tlast && !fill;
    forced = beat && !in_last && sum >= CW'(MAX_PACKET_BYTES);
    e_last = in_last || forced;
    id_ev = real_beat && state == MID && !id_seen && (tid_in != lock_tid || tdest_in != lock_tdest);
    gap_ev = fill && !gap_seen;
    state_n = state;
    count_n = count;
    if (state == DROP)
      state_n = axis_tx_in_tvalid && axis_tx_in_tlast ? IDLE : DROP;
    else if (beat) begin
      count_n = e_last ? '0 : sum;
      state_n = !e_last ? MID : (state == MID && forced && OVERSIZE_DROP_REMAINDER != 0) ? DROP : IDLE;
    end
    stall = axis_rx_in_tvalid && !axis_rx_out_tready;
    inc = timer >= rx_timeout_cycles ? rx_timeout_cycles : timer + 16'd1;
    timer_n = (INCLUDE_TIMEOUT_ERROR_INGR == 0 || (axis_rx_in_tvalid && axis_rx_out_tready) || err_clear[3] ||
               rx_timeout_cycles == '0) ? '0 : stall ? inc : timer;
    to_ev = INCLUDE_TIMEOUT_ERROR_INGR != 0 && rx_timeout_cycles != '0 && stall && timer != rx_timeout_cycles &&
            inc == rx_timeout_cycles;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      count <= '0;
      axis_tx_out_tvalid <= 1'b0;
      err_status <= '0;
      oversize_count <= '0;
      timer <= '0;
      gap_seen <= 1'b0;
      id_seen <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (slot) axis_tx_out_tvalid <= beat;
      err_status <= (err_status & ~err_clear) | {to_ev, id_ev, gap_ev, forced};
      oversize_count <= forced && !(&oversize_count) ? oversize_count + 1'b1 : oversize_count;
      timer <= timer_n;
      gap_seen <= beat && state == IDLE ? 1'b0 : gap_seen || fill;
      id_seen <= beat && state == IDLE ? 1'b0 : id_seen || id_ev;
    end
  end
  // datapath carries no reset; fields only move on an effective beat
  always_ff @(posedge aclk) begin
    if (beat) begin
      axis_tx_out_tdata <= fill ? '0 : axis_tx_in_tdata;
      axis_tx_out_tkeep <= fill ? '0 : axis_tx_in_tkeep;
      axis_tx_out_tlast <= e_last;
      axis_tx_out_tid <= state == IDLE ? tid_in : lock_tid;
      axis_tx_out_tdest <= state == IDLE ? tdest_in : lock_tdest;
    end
    if (beat && state == IDLE) begin
      lock_tid <= tid_in;
      lock_tdest <= tdest_in;
    end
  end
endmodule

// File: tb/tb_axis_prot_verifier_v2.sv
// tb_axis_prot_verifier_v2: directed self-checking bench for axis_prot_verifier_v2 (BYTES=8, MAX_PACKET_BYTES=24)
module tb_axis_prot_verifier_v2;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [63:0] tx_d = '0, o_d, rx_d = '0, ro_d;
  logic [3:0] tx_id = '0, tx_dst = '0, o_id, o_dst, rx_dst = '0, ro_dst;
  logic [7:0] tx_k = '0, o_k, rx_k = '0, ro_k;
  logic tx_l = 1'b0, tx_v = 1'b0, tx_rdy, o_l, o_v, out_rdy = 1'b1;
  logic rx_l = 1'b0, rx_v = 1'b0, rx_rdy, ro_l, ro_v, ro_rdy = 1'b1;
  logic [15:0] thr = 16'd10, ocnt;
  logic [3:0] err, clr = '0;
  logic irq;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic [3:0] id;} beat_t;
  beat_t q[$];
  always #5 aclk = ~aclk;
  axis_prot_verifier_v2 #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(4), .MAX_PACKET_BYTES(24)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_tx_in_tdata(tx_d), .axis_tx_in_tid(tx_id), .axis_tx_in_tdest(tx_dst), .axis_tx_in_tkeep(tx_k),
    .axis_tx_in_tlast(tx_l), .axis_tx_in_tvalid(tx_v), .axis_tx_in_tready(tx_rdy),
    .axis_tx_out_tdata(o_d), .axis_tx_out_tid(o_id), .axis_tx_out_tdest(o_dst), .axis_tx_out_tkeep(o_k),
    .axis_tx_out_tlast(o_l), .axis_tx_out_tvalid(o_v), .axis_tx_out_tready(out_rdy),
    .axis_rx_in_tdata(rx_d), .axis_rx_in_tdest(rx_dst), .axis_rx_in_tkeep(rx_k), .axis_rx_in_tlast(rx_l),
    .axis_rx_in_tvalid(rx_v), .axis_rx_in_tready(rx_rdy),
    .axis_rx_out_tdata(ro_d), .axis_rx_out_tdest(ro_dst), .axis_rx_out_tkeep(ro_k), .axis_rx_out_tlast(ro_l),
    .axis_rx_out_tvalid(ro_v), .axis_rx_out_tready(ro_rdy),
    .rx_timeout_cycles(thr), .err_status(err), .err_clear(clr), .err_irq(irq), .oversize_count(ocnt)
  );
  always @(negedge aclk) if (o_v && out_rdy) q.push_back(beat_t'({o_d, o_k, o_l, o_id}));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [3:0] id);
    tx_d = d; tx_k = k; tx_l = l; tx_id = id; tx_v = 1'b1;
    @(posedge aclk); #1;
  endtask
  task automatic gap(input int n);
    tx_v = 1'b0; tx_l = 1'b0;
    repeat (n) begin @(posedge aclk); #1; end
  endtask
  task automatic clear(input logic [3:0] m);
    clr = m;
    @(posedge aclk); #1;
    clr = '0;
  endtask
  initial begin
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid", 64'(o_v), 0);
    check("rst_err", 64'(err), 0);
    check("rst_irq", 64'(irq), 0);
    check("rst_ocnt", 64'(ocnt), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    // oversize: beat 3 forced last, beat 4 dropped
    send(1, 8'hFF, 0, 0); send(2, 8'hFF, 0, 0); send(3, 8'hFF, 0, 0); send(4, 8'hFF, 1, 0);
    gap(3);
    check("ovs_n", q.size(), 3);
    check("ovs_b1_last", 64'(q[1].l), 0);
    check("ovs_b2_last", 64'(q[2].l), 1);
    check("ovs_b2_data", q[2].d, 3);
    check("ovs_err", 64'(err), 4'b0001);
    check("ovs_irq", 64'(irq), 1);
    check("ovs_cnt", 64'(ocnt), 1);
    clear(4'b0001);
    check("clr0_err", 64'(err), 0);
    check("clr0_cnt", 64'(ocnt), 1);
    q.delete();
    // exactly MAX bytes with input tlast
    send(10, 8'hFF, 0, 0); send(11, 8'hFF, 0, 0); send(12, 8'hFF, 1, 0);
    gap(3);
    check("exact_n", q.size(), 3);
    check("exact_b0_last", 64'(q[0].l), 0);
    check("exact_b2_last", 64'(q[2].l), 1);
    check("exact_err", 64'(err), 0);
    q.delete();
    // 20-byte packet then a full 24-byte packet (count must restart at 0)
    send(20, 8'hFF, 0, 0); send(21, 8'hFF, 0, 0); send(22, 8'h0F, 1, 0);
    send(23, 8'hFF, 0, 0); send(24, 8'hFF, 0, 0); send(25, 8'hFF, 1, 0);
    gap(3);
    check("part_n", q.size(), 6);
    check("part_keep", 64'(q[2].k), 8'h0F);
    check("part_last", 64'(q[2].l), 1);
    check("next_b0_last", 64'(q[3].l), 0);
    check("next_b1_last", 64'(q[4].l), 0);
    check("next_b2_last", 64'(q[5].l), 1);
    check("part_err", 64'(err), 0);
    q.delete();
    // mid-packet gap of 2 cycles -> 2 fillers
    send(30, 8'hFF, 0, 7);
    gap(1);
    check("gap_tvalid", 64'(o_v), 1);
    gap(1);
    check("gap_tvalid2", 64'(o_v), 1);
    send(31, 8'hFF, 0, 7); send(32, 8'hFF, 1, 7);
    gap(3);
    check("gap_n", q.size(), 5);
    check("fill1_keep", 64'(q[1].k), 0);
    check("fill1_data", q[1].d, 0);
    check("fill2_keep", 64'(q[2].k), 0);
    check("fill2_tid", 64'(q[2].id), 7);
    check("gap_b4_last", 64'(q[4].l), 1);
    check("gap_err", 64'(err), 4'b0010);
    clear(4'b0010);
    q.delete();
    // tid changes mid-packet
    send(40, 8'hFF, 0, 3); send(41, 8'hFF, 0, 5); send(42, 8'hFF, 1, 5);
    gap(3);
    check("id_b0", 64'(q[0].id), 3);
    check("id_b1", 64'(q[1].id), 3);
    check("id_b2", 64'(q[2].id), 3);
    check("id_err", 64'(err), 4'b0100);
    clear(4'b0100);
    q.delete();
    send(43, 8'hFF, 1, 5);
    gap(2);
    check("id_new_n", q.size(), 1);
    check("id_new_tid", 64'(q[0].id), 5);
    check("id_new_err", 64'(err), 0);
    // rx stall timeout
    rx_d = 64'hABCD; rx_v = 1'b1; ro_rdy = 1'b0;
    #1;
    check("rx_pass_v", 64'(ro_v), 1);
    check("rx_pass_d", ro_d, 64'hABCD);
    check("rx_rdy", 64'(rx_rdy), 0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge aclk); #1;
      if (k == 9) check("to_before", 64'(err[3]), 0);
      if (k == 10) check("to_set", 64'(err[3]), 1);
    end
    check("to_irq", 64'(irq), 1);
    ro_rdy = 1'b1;
    clear(4'b1000);
    check("to_clr", 64'(err), 0);
    check("to_clr_irq", 64'(irq), 0);
    rx_v = 1'b0;
    // async reset mid-packet
    send(50, 8'hFF, 0, 2);
    tx_v = 1'b0;
    check("pre_rst_v", 64'(o_v), 1);
    #2 aresetn = 1'b0;
    #1 check("rst_async_v", 64'(o_v), 0);
    #3 aresetn = 1'b1;
    @(posedge aclk); #1;
    q.delete();
    send(51, 8'hFF, 1, 9);
    gap(2);
    check("post_rst_n", q.size(), 1);
    check("post_rst_tid", 64'(q[0].id), 9);
    check("post_rst_data", q[0].d, 51);
    check("post_rst_err", 64'(err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
